// File: rtl/adc_seq_avg.sv
// Conversion sequencer and 2^n result averager for a SAR ADC controller.
// Issues soc, captures data on eoc edges, delivers a rounded average on valid/ready.
module adc_seq_avg #(
    parameter int SIZE         = 12,
    parameter int MAX_AVG_LOG2 = 4,
    parameter int TMO_CYCLES   = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            trig,
    input  logic            cont,
    input  logic [2:0]      avg_log2,
    output logic            soc,
    input  logic            eoc,
    input  logic [SIZE-1:0] data_in,
    output logic [SIZE-1:0] result,
    output logic            result_valid,
    input  logic            result_ready,
    output logic            busy,
    output logic            overrun,
    output logic            timeout,
    input  logic            clr_flags
);

    localparam int ACC_W = SIZE + MAX_AVG_LOG2;
    localparam int SUM_W = ACC_W + 1;
    localparam int CNT_W = MAX_AVG_LOG2 + 1;
    localparam int TMO_W = 8;
    localparam logic [2:0]       MAX_N    = 3'(MAX_AVG_LOG2);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       n_q, n_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [SIZE-1:0]  result_q, result_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;
    logic             eoc_q;

    logic             eoc_evt;
    logic [2:0]       n_clamp;
    logic             cnt_last;
    logic [SUM_W-1:0] round_add;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] shifted;
    logic [SIZE-1:0]  avg_sat;

    assign eoc_evt  = eoc & ~eoc_q;
    assign n_clamp  = (avg_log2 > MAX_N) ? MAX_N : avg_log2;
    assign cnt_last = (cnt_q == CNT_W'((32'd1 << n_q) - 32'd1));

    // Half an LSB of the shifted result is added first so the shift rounds half up.
    assign round_add = (n_q == 3'd0) ? '0 : (SUM_W'(1) << (n_q - 3'd1));
    assign sum       = {1'b0, acc_q} + round_add;
    assign shifted   = sum >> n_q;
    assign avg_sat   = (|shifted[SUM_W-1:SIZE]) ? '1 : shifted[SIZE-1:0];

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        result_d  = result_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;

        // Clears come first so a flag set later in this block takes priority.
        if (clr_flags) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end
        if (valid_q && result_ready) begin
            valid_d = 1'b0;
        end

        if (!en) begin
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (trig || cont) begin
                        n_d     = n_clamp;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_START;
                    end
                end
                S_START: begin
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (eoc_evt) begin
                        acc_d   = acc_q + ACC_W'(data_in);
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = cnt_last ? S_DONE : S_START;
                    end else if (tmo_q == TMO_LAST) begin
                        timeout_d = 1'b1;
                        acc_d     = '0;
                        cnt_d     = '0;
                        state_d   = S_IDLE;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                S_DONE: begin
                    result_d = avg_sat;
                    valid_d  = 1'b1;
                    if (valid_q && !result_ready) begin
                        overrun_d = 1'b1;
                    end
                    if (cont) begin
                        n_d     = n_clamp;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            eoc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            eoc_q     <= eoc;
        end
    end

    assign soc          = (state_q == S_START) && en;
    assign busy         = (state_q != S_IDLE);
    assign result       = result_q;
    assign result_valid = valid_q;
    assign overrun      = overrun_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_adc_seq_avg.sv
// Directed bench for adc_seq_avg: a behavioural SAR controller answers each soc
// with one eoc pulse; results and flags are checked against hand-computed values.
module tb_adc_seq_avg;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        trig;
    logic        cont;
    logic [2:0]  avg_log2;
    logic        soc;
    logic        eoc;
    logic [11:0] data_in;
    logic [11:0] result;
    logic        result_valid;
    logic        result_ready;
    logic        busy;
    logic        overrun;
    logic        timeout;
    logic        clr_flags;

    int vectors     = 0;
    int miscompares = 0;
    int soc_cnt     = 0;
    int s0          = 0;
    logic mon_busy  = 1'b0;
    logic busy_gap  = 1'b0;

    adc_seq_avg #(.SIZE(12), .MAX_AVG_LOG2(4), .TMO_CYCLES(255)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .trig         (trig),
        .cont         (cont),
        .avg_log2     (avg_log2),
        .soc          (soc),
        .eoc          (eoc),
        .data_in      (data_in),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .overrun      (overrun),
        .timeout      (timeout),
        .clr_flags    (clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (soc) soc_cnt <= soc_cnt + 1;
        if (mon_busy && !busy) busy_gap <= 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    // Waits (bounded) for soc, then returns one eoc pulse dly cycles later; ends in cycle E+1.
    task automatic conv(input int dly, input logic [11:0] d);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (soc) found = 1'b1;
            else tick();
        end
        check("soc_seen", {31'd0, found}, 32'd1);
        repeat (dly) tick();
        eoc     = 1'b1;
        data_in = d;
        tick();
        eoc = 1'b0;
    endtask

    task automatic consume();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; trig = 1'b0; cont = 1'b0; avg_log2 = 3'd0;
        eoc = 1'b0; data_in = 12'd0; result_ready = 1'b0; clr_flags = 1'b0;
        repeat (3) tick();
        check("rst_outputs", {24'd0, soc, result_valid, busy, overrun, timeout, 3'd0}, 32'd0);
        check("rst_result", {20'd0, result}, 32'd0);
        rst_n = 1'b1;
        tick();
        en = 1'b1;

        // 1: n=0 one-shot, eoc 60 clks after soc
        s0 = soc_cnt;
        pulse_trig();
        conv(60, 12'hA5C);
        check("t1_valid_e1", {31'd0, result_valid}, 32'd0);
        tick();
        check("t1_valid_e2", {31'd0, result_valid}, 32'd1);
        check("t1_result", {20'd0, result}, 32'h0A5C);
        check("t1_soc_count", soc_cnt - s0, 32'd1);
        consume();
        check("t1_handshake_clear", {31'd0, result_valid}, 32'd0);

        // 2: n=2, 100+101+102+103=406, (406+2)>>2 = 102
        avg_log2 = 3'd2;
        s0 = soc_cnt;
        pulse_trig();
        busy_gap = 1'b0;
        mon_busy = 1'b1;
        conv(3, 12'd100);
        conv(4, 12'd101);
        conv(2, 12'd102);
        conv(5, 12'd103);
        mon_busy = 1'b0;
        tick();
        check("t2_result", {20'd0, result}, 32'd102);
        check("t2_valid", {31'd0, result_valid}, 32'd1);
        check("t2_soc_count", soc_cnt - s0, 32'd4);
        check("t2_busy_gap", {31'd0, busy_gap}, 32'd0);
        check("t2_idle", {31'd0, busy}, 32'd0);
        consume();

        // 3: avg_log2=7 clamps to 4; sixteen full-scale samples average to 12'hFFF
        avg_log2 = 3'd7;
        s0 = soc_cnt;
        pulse_trig();
        for (int k = 0; k < 16; k++) conv(2, 12'hFFF);
        tick();
        check("t3_result", {20'd0, result}, 32'h0FFF);
        check("t3_soc_count", soc_cnt - s0, 32'd16);

        // 3b: new load coincides with handshake of the old one: valid stays, no overrun
        avg_log2 = 3'd0;
        pulse_trig();
        conv(3, 12'h321);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("t3b_valid", {31'd0, result_valid}, 32'd1);
        check("t3b_result", {20'd0, result}, 32'h0321);
        check("t3b_no_overrun", {31'd0, overrun}, 32'd0);
        consume();
        check("t3b_cleared", {31'd0, result_valid}, 32'd0);

        // 4: continuous, consumer not ready: second result overwrites, overrun sticky
        cont = 1'b1;
        conv(4, 12'h123);
        tick();
        check("t4_first_result", {20'd0, result}, 32'h0123);
        check("t4_first_overrun", {31'd0, overrun}, 32'd0);
        check("t4_restart_soc", {31'd0, soc}, 32'd1);
        cont = 1'b0;
        conv(4, 12'h456);
        tick();
        check("t4_second_result", {20'd0, result}, 32'h0456);
        check("t4_overrun", {31'd0, overrun}, 32'd1);
        check("t4_idle", {31'd0, busy}, 32'd0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("t4_overrun_clr", {31'd0, overrun}, 32'd0);
        check("t4_valid_kept", {31'd0, result_valid}, 32'd1);
        consume();

        // 5: eoc never rises; timeout after 255 WAIT cycles, then a trig recovers
        pulse_trig();
        check("t5_soc", {31'd0, soc}, 32'd1);
        s0 = soc_cnt;
        repeat (255) tick();
        check("t5_no_timeout_yet", {30'd0, timeout, busy}, 32'd1);
        tick();
        check("t5_timeout", {30'd0, timeout, busy}, 32'd2);
        check("t5_soc_once", soc_cnt - s0, 32'd1);
        check("t5_no_result", {31'd0, result_valid}, 32'd0);
        pulse_trig();
        conv(3, 12'h0F0);
        tick();
        check("t5_retry_result", {20'd0, result}, 32'h00F0);
        check("t5_timeout_sticky", {31'd0, timeout}, 32'd1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("t5_timeout_clr", {31'd0, timeout}, 32'd0);
        consume();

        // 6: n=3, abort after 5 samples; fresh 8 samples 10..17 -> (108+4)>>3 = 14
        avg_log2 = 3'd3;
        pulse_trig();
        for (int k = 0; k < 5; k++) conv(2, 12'h7FF);
        tick();
        en = 1'b0;
        tick();
        check("t6_abort_idle", {31'd0, busy}, 32'd0);
        tick();
        check("t6_no_result", {31'd0, result_valid}, 32'd0);
        en = 1'b1;
        s0 = soc_cnt;
        pulse_trig();
        for (int k = 0; k < 8; k++) conv(2, 12'(10 + k));
        tick();
        check("t6_result", {20'd0, result}, 32'd14);
        check("t6_soc_count", soc_cnt - s0, 32'd8);
        consume();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
